mem_bus_arbiter: RTL

//  Shares the single-port instruction/data memory between two bus masters:
//  m0 = CORE load/store/fetch port, m1 = debug/program-loader port.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 101 ++++++++++
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory bus arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, ACCESS, RESP)
//   NUM_MASTERS : number of bus masters sharing the memory
//   M_CORE      : index of the core load/store/fetch master
//   M_DBG       : index of the debug / program-loader master
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int NUM_MASTERS = 2;
  localparam int M_CORE      = 0;
  localparam int M_DBG       = 1;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant selection for the memory bus arbiter.
// Holds the rr_last pointer (the master that was accepted most recently,
// which is also the current owner) and, when MEM_ARB_LOCK_EN is defined,
// the owner lock flag.
//
// Optional feature macro: MEM_ARB_LOCK_EN (adds lock_i and lock masking).
//
// Ports:
//   clk          in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   sel_en_i     in   selection allowed this cycle (FSM in IDLE/RESP, not in reset)
//   req_valid_i  in   per-master request valid
//   lock_i       in   per-master lock request, sampled at accept (MEM_ARB_LOCK_EN)
//   grant_o      out  one-hot selected master, zero when nothing is selected
//   accept_o     out  a grant is being handshaken this cycle
//   owner_o      out  master accepted most recently (rr_last)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic                   sel_en_i,
  input  logic [NUM_MASTERS-1:0] req_valid_i,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0] lock_i,
`endif
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   accept_o,
  output logic                   owner_o
);

  logic                   rr_last_q, rr_last_d;
  logic [NUM_MASTERS-1:0] elig;
  logic [NUM_MASTERS-1:0] sel;
  logic                   acc_idx;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_d;
`endif

  always_comb begin
    elig = req_valid_i;
`ifdef MEM_ARB_LOCK_EN
    // A locked owner shuts the other master out, even while the owner is idle.
    if (lock_q) begin
      elig = rr_last_q ? (req_valid_i & 2'b10) : (req_valid_i & 2'b01);
    end
`endif
    sel = '0;
    case (elig)
      2'b01:   sel[M_CORE] = 1'b1;
      2'b10:   sel[M_DBG]  = 1'b1;
      // Contention: the master that did not win last time goes next.
      2'b11:   sel = rr_last_q ? 2'b01 : 2'b10;
      default: sel = '0;
    endcase
    grant_o = sel_en_i ? sel : '0;
  end

  assign accept_o = |(grant_o & req_valid_i);
  assign acc_idx  = grant_o[M_DBG];
  assign owner_o  = rr_last_q;

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept_o) begin
      rr_last_d = acc_idx;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // An accept by the owner with its lock bit low releases the lock.
  always_comb begin
    lock_d = lock_q;
    if (accept_o) begin
      lock_d = lock_i[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`endif

  // rr_last resets to the debug master so the core wins the first contention.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares a single-port instruction/data memory between the core port (m0)
// and the debug/program-loader port (m1). Valid/ready request handshake,
// round-robin arbitration, one registered memory access cycle and a
// one-cycle response pulse to the owning master.
//
// Optional feature macro: MEM_ARB_LOCK_EN (adds the lock port; a locked
// owner keeps the bus until it is accepted again with its lock bit low).
//
// Parameters:
//   DATA_WIDTH  data bus width
//   ADDR_WIDTH  address width
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   lock       in   per-master lock request (MEM_ARB_LOCK_EN only)
//   req_valid  in   per-master request valid
//   req_ready  out  per-master accept, combinational
//   req_we     in   per-master write enable
//   req_addr   in   {m1, m0} addresses
//   req_wdata  in   {m1, m0} write data
//   rsp_valid  out  one-cycle response pulse to the owner
//   rsp_rdata  out  read data (zero for writes), qualified by rsp_valid
//   mem_addr   out  registered memory address
//   mem_wdata  out  registered memory write data
//   mem_we     out  write strobe, high only in ACCESS for a write
//   mem_rdata  in   memory read data, combinational from mem_addr
//   busy       out  high while in ACCESS
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]            lock,
`endif
  input  logic [NUM_MASTERS-1:0]            req_valid,
  output logic [NUM_MASTERS-1:0]            req_ready,
  input  logic [NUM_MASTERS-1:0]            req_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_MASTERS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_rdata,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic                              mem_we,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy
);

  arb_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   we_q, we_d;
  logic [NUM_MASTERS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic                   sel_en;
  logic [NUM_MASTERS-1:0] grant;
  logic                   accept;
  logic                   owner;
  logic                   acc_idx;

  // Selection is only offered outside ACCESS, and never while reset is held.
  assign sel_en = reset && (state_q != ACCESS);

  rr_arbiter2 u_rr (
    .clk         (clk),
    .rst_ni      (reset),
    .sel_en_i    (sel_en),
    .req_valid_i (req_valid),
`ifdef MEM_ARB_LOCK_EN
    .lock_i      (lock),
`endif
    .grant_o     (grant),
    .accept_o    (accept),
    .owner_o     (owner)
  );

  assign acc_idx = grant[M_DBG];

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    we_d        = we_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d     = ACCESS;
          mem_addr_d  = acc_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : req_addr[ADDR_WIDTH-1:0];
          mem_wdata_d = acc_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                : req_wdata[DATA_WIDTH-1:0];
          we_d        = req_we[acc_idx];
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // The owner equals rr_last, which was updated at accept.
        rsp_rdata_d        = we_q ? '0 : mem_rdata;
        rsp_valid_d[owner] = 1'b1;
        state_d            = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      we_q        <= we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = grant;
  assign busy      = (state_q == ACCESS);
  // Derived only from flops, so it drops the instant reset is asserted.
  assign mem_we    = busy && we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
